// File: rtl/demux1to16_frame.sv
// rtl/demux1to16_frame.sv - serial-to-parallel frame receiver for the 16-to-1 mux link
module demux1to16_frame #(
    parameter int NCH  = 16,
    parameter int SELW = 4,
    parameter int CONT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in,
    input  logic            in_valid,
    output logic [NCH-1:0]  out,
    output logic            out_valid,
    output logic [SELW-1:0] sel,
    output logic            busy,
    output logic            frame_err
);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    localparam logic [SELW-1:0] SEL_ZERO = '0;
    localparam logic [SELW-1:0] SEL_ONE  = SELW'(1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(NCH - 1);
    localparam logic [NCH-1:0]  ZERO     = '0;

    state_t          state;
    logic [NCH-1:0]  shadow;
    logic [NCH-1:0]  first_word;
    logic            frame_done;

    // Shadow contents when a frame restarts with a valid bit landing on channel 0.
    always_comb begin
        first_word    = ZERO;
        first_word[0] = in;
    end

    // The last channel of a frame is being filled this cycle.
    always_comb begin
        frame_done = 1'b0;
        if (state == COLLECT && in_valid && sel == SEL_LAST) begin
            frame_done = 1'b1;
        end
    end

    // Frame sequencer: collects bits into the shadow and publishes complete words.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= SEL_ZERO;
            shadow    <= ZERO;
            out       <= ZERO;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= COLLECT;
                        busy  <= 1'b1;
                        if (in_valid) begin
                            shadow <= first_word;
                            sel    <= SEL_ONE;
                        end else begin
                            shadow <= ZERO;
                            sel    <= SEL_ZERO;
                        end
                    end else if (in_valid) begin
                        // A bit with no frame open has nowhere to go.
                        frame_err <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (frame_done) begin
                        // The final bit belongs to the current frame even if start arrives with it.
                        out       <= {in, shadow[NCH-2:0]};
                        out_valid <= 1'b1;
                        sel       <= sel + SEL_ONE;
                        shadow    <= ZERO;
                        if (start || CONT != 0) begin
                            state <= COLLECT;
                            busy  <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (start) begin
                        // sel at zero means nothing has been collected, so nothing is lost.
                        if (sel != SEL_ZERO) begin
                            frame_err <= 1'b1;
                        end
                        if (in_valid) begin
                            shadow <= first_word;
                            sel    <= SEL_ONE;
                        end else begin
                            shadow <= ZERO;
                            sel    <= SEL_ZERO;
                        end
                    end else if (in_valid) begin
                        shadow[sel] <= in;
                        sel         <= sel + SEL_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux1to16_frame.sv
// tb/tb_demux1to16_frame.sv - scoreboard bench for demux1to16_frame
module tb_demux1to16_frame;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, in0, v0;
    logic        start1, in1, v1;
    logic [15:0] out0, out1;
    logic        ov0, ov1;
    logic [3:0]  sel0, sel1;
    logic        busy0, busy1;
    logic        err0, err1;

    int errors = 0;
    int checks = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    demux1to16_frame #(.NCH(16), .SELW(4), .CONT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .in(in0), .in_valid(v0),
        .out(out0), .out_valid(ov0), .sel(sel0), .busy(busy0), .frame_err(err0)
    );

    demux1to16_frame #(.NCH(16), .SELW(4), .CONT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in(in1), .in_valid(v1),
        .out(out1), .out_valid(ov1), .sel(sel1), .busy(busy1), .frame_err(err1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: every out_valid pulse must match the next queued frame.
    always @(negedge clk) begin
        if (ov0 === 1'b1) begin
            if (q0.size() == 0) begin
                chk("dut0 unexpected out_valid", {16'h0, out0}, 32'hdead);
            end else begin
                chk("dut0 frame", {16'h0, out0}, {16'h0, q0.pop_front()});
            end
        end
        if (ov1 === 1'b1) begin
            if (q1.size() == 0) begin
                chk("dut1 unexpected out_valid", {16'h0, out1}, 32'hdead);
            end else begin
                chk("dut1 frame", {16'h0, out1}, {16'h0, q1.pop_front()});
            end
        end
    end

    task automatic drive0(input logic s, input logic v, input logic b);
        start0 = s; v0 = v; in0 = b;
        @(posedge clk); #1;
        start0 = 1'b0; v0 = 1'b0; in0 = 1'b0;
    endtask

    task automatic drive1(input logic s, input logic v, input logic b);
        start1 = s; v1 = v; in1 = b;
        @(posedge clk); #1;
        start1 = 1'b0; v1 = 1'b0; in1 = 1'b0;
    endtask

    task automatic reset2;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        start0 = 0; in0 = 0; v0 = 0;
        start1 = 0; in1 = 0; v1 = 0;

        // Reset values.
        reset2();
        chk("reset out", {16'h0, out0}, 32'h0);
        chk("reset sel", {28'h0, sel0}, 32'h0);
        chk("reset busy", {31'h0, busy0}, 32'h0);
        chk("reset out_valid", {31'h0, ov0}, 32'h0);
        chk("reset frame_err", {31'h0, err0}, 32'h0);

        // Plain frame 30ab.
        w = 16'h30ab;
        drive0(1, 0, 0);
        chk("start busy", {31'h0, busy0}, 32'h1);
        chk("start sel", {28'h0, sel0}, 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) q0.push_back(16'h30ab);
            drive0(0, 1, w[k]);
            if (k == 5) chk("sel after ch5", {28'h0, sel0}, 32'h6);
        end
        chk("latency out_valid", {31'h0, ov0}, 32'h1);
        chk("frame out", {16'h0, out0}, 32'h30ab);
        chk("done busy", {31'h0, busy0}, 32'h0);
        chk("done sel", {28'h0, sel0}, 32'h0);
        drive0(0, 0, 0);
        chk("pulse width", {31'h0, ov0}, 32'h0);

        // Same frame with gaps after channel 5 and channel 12.
        drive0(1, 0, 0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) q0.push_back(16'h30ab);
            drive0(0, 1, w[k]);
            if (k == 5 || k == 12) begin
                for (int g = 0; g < 3; g++) begin
                    drive0(0, 0, 1);
                    chk("gap sel", {28'h0, sel0}, (k == 5) ? 32'h6 : 32'hd);
                    chk("gap out_valid", {31'h0, ov0}, 32'h0);
                end
            end
        end
        chk("gap frame out", {16'h0, out0}, 32'h30ab);

        // in_valid while idle.
        drive0(0, 1, 1);
        chk("idle valid err", {31'h0, err0}, 32'h1);
        chk("idle valid out", {16'h0, out0}, 32'h30ab);
        chk("idle valid sel", {28'h0, sel0}, 32'h0);
        chk("idle valid busy", {31'h0, busy0}, 32'h0);

        // Reset mid-frame.
        drive0(1, 0, 0);
        for (int k = 0; k < 5; k++) drive0(0, 1, 1);
        reset2();
        chk("midrst out", {16'h0, out0}, 32'h0);
        chk("midrst sel", {28'h0, sel0}, 32'h0);
        chk("midrst busy", {31'h0, busy0}, 32'h0);
        chk("midrst out_valid", {31'h0, ov0}, 32'h0);
        chk("midrst frame_err", {31'h0, err0}, 32'h0);

        // start with the first bit, and start again with the 16th bit.
        w = 16'h00a5;
        for (int k = 0; k < 16; k++) begin
            if (k == 15) q0.push_back(16'h00a5);
            drive0((k == 0 || k == 15), 1, w[k]);
            if (k == 0) chk("coincide sel", {28'h0, sel0}, 32'h1);
        end
        chk("restart out", {16'h0, out0}, 32'h00a5);
        chk("restart busy", {31'h0, busy0}, 32'h1);
        chk("restart sel", {28'h0, sel0}, 32'h0);
        chk("restart err", {31'h0, err0}, 32'h0);

        // start at sel=0 is harmless; start after 7 bits aborts.
        drive0(1, 0, 0);
        chk("empty restart err", {31'h0, err0}, 32'h0);
        for (int k = 0; k < 7; k++) drive0(0, 1, 0);
        chk("abort sel", {28'h0, sel0}, 32'h7);
        drive0(1, 0, 0);
        chk("abort err", {31'h0, err0}, 32'h1);
        chk("abort sel reset", {28'h0, sel0}, 32'h0);
        for (int k = 0; k < 16; k++) begin
            if (k == 15) q0.push_back(16'hffff);
            drive0(0, 1, 1);
        end
        chk("abort frame out", {16'h0, out0}, 32'hffff);
        drive0(0, 0, 0);

        // Continuous mode: two back-to-back frames.
        drive1(1, 0, 0);
        for (int f = 0; f < 2; f++) begin
            w = (f == 0) ? 16'h1234 : 16'habcd;
            for (int k = 0; k < 16; k++) begin
                if (k == 15) q1.push_back(w);
                drive1(0, 1, w[k]);
            end
            chk("cont out", {16'h0, out1}, (f == 0) ? 32'h1234 : 32'habcd);
            chk("cont busy", {31'h0, busy1}, 32'h1);
            chk("cont sel", {28'h0, sel1}, 32'h0);
        end
        drive1(0, 0, 0);
        chk("cont err", {31'h0, err1}, 32'h0);

        drive0(0, 0, 0);
        chk("dut0 frames outstanding", q0.size(), 32'h0);
        chk("dut1 frames outstanding", q1.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
